// File: rtl/endmember_search.sv
// endmember_search: multi-pass farthest-pixel endmember extractor for band-serial hyperspectral frames.
// Build option L1_DIST_EN selects Manhattan distance; the default build uses squared Euclidean distance.
module endmember_search #(
   parameter int SPECTRAL_BANDS   = 100,
   parameter int WIDTH            = 16,
   parameter int MAC_WIDTH        = 36,
   parameter int TOTAL_PIXELS     = 100000,
   parameter int TOTAL_ENDMEMBERS = 20,
   localparam int PC_W   = $clog2(TOTAL_ENDMEMBERS + 1),
   localparam int IDX_W  = (TOTAL_PIXELS > 1) ? $clog2(TOTAL_PIXELS) : 1,
   localparam int ADDR_W = (TOTAL_ENDMEMBERS * SPECTRAL_BANDS > 1) ?
                           $clog2(TOTAL_ENDMEMBERS * SPECTRAL_BANDS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     pixel_in,
   input  logic                 in_axi_valid,
   output logic                 out_axi_ready,
   output logic                 intr,
   output logic [1:0]           state,
   output logic [PC_W-1:0]      pass_count,
   output logic [MAC_WIDTH-1:0] max_dist,
   output logic [IDX_W-1:0]     max_idx,
   output logic                 finish,
   input  logic [ADDR_W-1:0]    em_rd_addr,
   output logic [WIDTH-1:0]     em_rd_data
);
   localparam int BAND_W   = $clog2(SPECTRAL_BANDS);
   localparam int EM_DEPTH = TOTAL_ENDMEMBERS * SPECTRAL_BANDS;

   typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, COMMIT = 2'd2, FINISH = 2'd3} state_t;

   state_t                cur, nxt;
   logic                  enter_search;
   logic [BAND_W-1:0]     band;
   logic [IDX_W-1:0]      pix;
   logic                  sel;
   logic [MAC_WIDTH-1:0]  acc;
   logic [WIDTH-1:0]      stage_mem [2][SPECTRAL_BANDS];
   logic [WIDTH-1:0]      em_mem [EM_DEPTH];

   logic [ADDR_W-1:0]     ref_addr, cmt_addr;
   logic [WIDTH-1:0]      ref_val;
   logic signed [WIDTH:0] diff;
   logic [MAC_WIDTH-1:0]  term, acc_base, acc_next;
   logic                  beat, last_band, last_pix, capture;

   function automatic logic [MAC_WIDTH-1:0] dist_term(input logic signed [WIDTH:0] d);
      logic [WIDTH-1:0] mag;
`ifdef L1_DIST_EN
      mag = d[WIDTH] ? WIDTH'(-d) : d[WIDTH-1:0];
      return MAC_WIDTH'(mag);
`else
      logic [2*WIDTH-1:0] sq;
      mag = d[WIDTH] ? WIDTH'(-d) : d[WIDTH-1:0];
      sq  = (2*WIDTH)'(mag) * (2*WIDTH)'(mag);
      return MAC_WIDTH'(sq);
`endif
   endfunction

   function automatic logic [MAC_WIDTH-1:0] sat_add(input logic [MAC_WIDTH-1:0] a,
                                                    input logic [MAC_WIDTH-1:0] b);
      logic [MAC_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[MAC_WIDTH] ? {MAC_WIDTH{1'b1}} : s[MAC_WIDTH-1:0];
   endfunction

   // Reference for pass k>0 is slot k-1, read combinationally so beats never stall.
   assign ref_addr  = ADDR_W'(int'(pass_count) * SPECTRAL_BANDS + int'(band) - SPECTRAL_BANDS);
   assign cmt_addr  = ADDR_W'(int'(pass_count) * SPECTRAL_BANDS + int'(band));
   assign ref_val   = (pass_count == '0) ? '0 : em_mem[ref_addr];
   assign diff      = $signed({1'b0, pixel_in}) - $signed({1'b0, ref_val});
   assign term      = dist_term(diff);
   assign acc_base  = (band == '0) ? '0 : acc;
   assign acc_next  = sat_add(acc_base, term);

   assign beat      = in_axi_valid && (cur == SEARCH);
   assign last_band = (band == BAND_W'(SPECTRAL_BANDS - 1));
   assign last_pix  = (pix == IDX_W'(TOTAL_PIXELS - 1));
   assign capture   = beat && last_band && ((pix == '0) || (acc_next > max_dist));

   assign out_axi_ready = (cur == SEARCH);
   assign finish        = (cur == FINISH);
   assign state         = cur;

   always_comb begin
      nxt          = cur;
      enter_search = 1'b0;
      case (cur)
         IDLE, FINISH: begin
            if (start) begin
               nxt          = SEARCH;
               enter_search = 1'b1;
            end
         end
         SEARCH: begin
            if (beat && last_band && last_pix) nxt = COMMIT;
         end
         COMMIT: begin
            if (last_band) begin
               if (pass_count == PC_W'(TOTAL_ENDMEMBERS - 1)) begin
                  nxt = FINISH;
               end else begin
                  nxt          = SEARCH;
                  enter_search = 1'b1;
               end
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur        <= IDLE;
         intr       <= 1'b0;
         pass_count <= '0;
         max_dist   <= '0;
         max_idx    <= '0;
         band       <= '0;
         pix        <= '0;
         sel        <= 1'b0;
         em_rd_data <= '0;
      end else begin
         cur        <= nxt;
         intr       <= enter_search;
         em_rd_data <= em_mem[em_rd_addr];
         if (enter_search) begin
            band     <= '0;
            pix      <= '0;
            max_dist <= '0;
         end
         if ((cur == IDLE || cur == FINISH) && start) pass_count <= '0;
         if (beat) begin
            if (last_band) begin
               band <= '0;
               pix  <= last_pix ? '0 : pix + 1'b1;
            end else begin
               band <= band + 1'b1;
            end
         end
         // Capture swaps staging and candidate buffers instead of copying the pixel.
         if (capture) begin
            max_dist <= acc_next;
            max_idx  <= pix;
            sel      <= ~sel;
         end
         if (cur == COMMIT) begin
            if (last_band) begin
               band       <= '0;
               pass_count <= pass_count + 1'b1;
            end else begin
               band <= band + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (beat) begin
         acc                  <= acc_next;
         stage_mem[sel][band] <= pixel_in;
      end
      if (cur == COMMIT) em_mem[cmt_addr] <= stage_mem[~sel][band];
   end

endmodule

// File: tb/tb_endmember_search.sv
// tb_endmember_search: table-driven extraction scenarios with a pass-result scoreboard.
module tb_endmember_search;
   localparam int B = 4, P = 3, E = 2, W = 8, MW = 16;

`ifdef L1_DIST_EN
   localparam logic [15:0] B_MD0 = 16'd20,     B_MD1 = 16'd16;
   localparam logic [15:0] T_MD0 = 16'd10,     T_MD1 = 16'd10;
   localparam logic [15:0] S_MD0 = 16'd1020,   S_MD1 = 16'd1020;
`else
   localparam logic [15:0] B_MD0 = 16'd100,    B_MD1 = 16'd64;
   localparam logic [15:0] T_MD0 = 16'd30,     T_MD1 = 16'd30;
   localparam logic [15:0] S_MD0 = 16'hFFFF,   S_MD1 = 16'hFFFF;
`endif

   logic          clk = 1'b0;
   logic          rst, start, in_axi_valid, out_axi_ready, intr, finish;
   logic [W-1:0]  pixel_in, em_rd_data;
   logic [1:0]    state, pass_count, max_idx;
   logic [MW-1:0] max_dist;
   logic [2:0]    em_rd_addr;

   always #5 clk = ~clk;

   endmember_search #(
      .SPECTRAL_BANDS(B), .WIDTH(W), .MAC_WIDTH(MW), .TOTAL_PIXELS(P), .TOTAL_ENDMEMBERS(E)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in), .in_axi_valid(in_axi_valid),
      .out_axi_ready(out_axi_ready), .intr(intr), .state(state), .pass_count(pass_count),
      .max_dist(max_dist), .max_idx(max_idx), .finish(finish),
      .em_rd_addr(em_rd_addr), .em_rd_data(em_rd_data)
   );

   typedef struct packed {
      logic [31:0] p0, p1, p2;
      logic [15:0] md0;
      logic [1:0]  idx0;
      logic [15:0] md1;
      logic [1:0]  idx1;
      logic [31:0] slot0, slot1;
   } vec_t;

   typedef struct packed {
      logic [15:0] md;
      logic [1:0]  idx;
   } exp_t;

   vec_t tbl [4];
   exp_t sb_q [$];
   exp_t e_pop;
   int   checks = 0, passes = 0, intr_cnt = 0, beat_cnt = 0;
   logic [1:0] prev_state = 2'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passes++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pops one expected pass result whenever a pass ends (SEARCH -> COMMIT).
   always @(negedge clk) begin
      if (!rst && intr) intr_cnt++;
      if (!rst && in_axi_valid && out_axi_ready) beat_cnt++;
      if (state == 2'd2 && prev_state == 2'd1) begin
         if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 64'd1, 64'd0);
         end else begin
            e_pop = sb_q.pop_front();
            check("pass_max_dist", 64'(max_dist), 64'(e_pop.md));
            check("pass_max_idx", 64'(max_idx), 64'(e_pop.idx));
         end
      end
      prev_state = state;
   end

   task automatic send_beat(input logic [7:0] d, input bit gaps);
      int n;
      if (gaps && $urandom_range(0, 2) == 0) begin
         in_axi_valid = 1'b0;
         tick();
      end
      pixel_in     = d;
      in_axi_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!out_axi_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!out_axi_ready) check("ready_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_pass(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input bit gaps, input bit hold_valid);
      logic [31:0] fr [3];
      logic [31:0] px;
      int n;
      fr[0] = a; fr[1] = b; fr[2] = c;
      for (int p = 0; p < P; p++) begin
         px = fr[p];
         for (int k = 0; k < B; k++) send_beat(px[8*k +: 8], gaps);
      end
      if (hold_valid) begin
         pixel_in     = 8'hAA;
         in_axi_valid = 1'b1;
         n = 0;
         while (state == 2'd2 && n < 50) begin
            tick();
            n++;
         end
      end else begin
         in_axi_valid = 1'b0;
      end
   endtask

   task automatic run_extraction(input vec_t v, input bit gaps, input bit hold_valid);
      int n;
      logic [31:0] slot;
      intr_cnt = 0;
      beat_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      sb_q.push_back({v.md0, v.idx0});
      run_pass(v.p0, v.p1, v.p2, gaps, hold_valid);
      sb_q.push_back({v.md1, v.idx1});
      run_pass(v.p0, v.p1, v.p2, gaps, hold_valid);
      n = 0;
      while (state != 2'd3 && n < 100) begin
         tick();
         n++;
      end
      in_axi_valid = 1'b0;
      check("finish", 64'(finish), 64'd1);
      check("pass_count", 64'(pass_count), 64'd2);
      check("final_max_dist", 64'(max_dist), 64'(v.md1));
      check("final_max_idx", 64'(max_idx), 64'(v.idx1));
      check("intr_pulses", 64'(intr_cnt), 64'd2);
      check("beats_accepted", 64'(beat_cnt), 64'(B * P * 2));
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      for (int s = 0; s < E; s++) begin
         for (int k = 0; k < B; k++) begin
            em_rd_addr = 3'(s * B + k);
            tick();
            slot[8*k +: 8] = em_rd_data;
         end
         check(s == 0 ? "slot0" : "slot1", 64'(slot), 64'(s == 0 ? v.slot0 : v.slot1));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 64'(state), 64'd0);
      check({tag, "_ready"}, 64'(out_axi_ready), 64'd0);
      check({tag, "_intr"}, 64'(intr), 64'd0);
      check({tag, "_finish"}, 64'(finish), 64'd0);
      check({tag, "_pass_count"}, 64'(pass_count), 64'd0);
      check({tag, "_max_dist"}, 64'(max_dist), 64'd0);
      check({tag, "_max_idx"}, 64'(max_idx), 64'd0);
      check({tag, "_em_rd_data"}, 64'(em_rd_data), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{32'h01010101, 32'h05050505, 32'h02020202, B_MD0, 2'd1, B_MD1, 2'd0,
                 32'h05050505, 32'h01010101};
      tbl[1] = '{32'h00000000, 32'h00000000, 32'h00000000, 16'd0, 2'd0, 16'd0, 2'd0,
                 32'h00000000, 32'h00000000};
      tbl[2] = '{32'h00000000, 32'h01020304, 32'h04030201, T_MD0, 2'd1, T_MD1, 2'd0,
                 32'h01020304, 32'h00000000};
      tbl[3] = '{32'hFFFFFFFF, 32'h00000000, 32'h01010101, S_MD0, 2'd0, S_MD1, 2'd1,
                 32'hFFFFFFFF, 32'h00000000};

      rst = 1'b1; start = 1'b0; in_axi_valid = 1'b0; pixel_in = '0; em_rd_addr = '0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) run_extraction(tbl[i], 1'b0, 1'b0);

      run_extraction(tbl[0], 1'b1, 1'b1);

      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 6; k++) send_beat(8'(k < 4 ? 1 : 5), 1'b0);
      in_axi_valid = 1'b0;
      rst = 1'b1;
      tick();
      check_reset_outputs("midreset");
      rst = 1'b0;
      tick();
      run_extraction(tbl[0], 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
